btn_event_arbiter: RTL
======================

// Module: btn_event_arbiter
// PURPOSE
//  Consumes the synchronized button vector, debounces each channel and turns
//  presses into one-shot events. Round-robin arbitrates simultaneous presses
//  into a single valid/ready event stream (evt_id) for the game FSM.
//  Sits between the 3-flop input synchronizer and the craps controller.
// PARAMETERS
//  N_BTN           4           number of button channels
//  ID_W            2           width of evt_id, = log2(N_BTN)
//  DEBOUNCE_CYCLES 1000000     consecutive differing samples to accept a level change (10 ms)
//  CNT_W           20          debounce counter width, must hold DEBOUNCE_CYCLES-1
//  REPEAT_CYCLES   50000000    autorepeat period in cycles (0.5 s), only with BTN_AUTOREPEAT_EN
//  RPT_W           26          repeat counter width, must hold REPEAT_CYCLES-1
// PORTS
//  Clk100MHz  in   1      system clock, 100 MHz
//  reset_n    in   1      synchronous, active-low reset
//  sync_btn   in   N_BTN  synchronized raw button levels
//  evt_ready  in   1      consumer accepts the event when high with evt_valid
//  ovf_clr    in   1      clears sticky overflow
//  evt_valid  out  1      event offered
//  evt_id     out  ID_W   index of the pressed button; stable while evt_valid
//  btn_level  out  N_BTN  debounced levels
//  pending    out  N_BTN  press recorded, not yet loaded into the offer
//  overflow   out  1      sticky: a press was dropped because pending was already set
// BEHAVIOUR
//  Reset: on any edge with reset_n=0, all outputs and regs go to 0, rr_ptr=0, state IDLE.
//   A reset mid-offer discards the offered event.
//   A button held through reset re-debounces and produces a fresh press.
//  Debounce (per ch i):
//   - sync_btn[i]==btn_level[i]: cnt[i]<=0.
//   - otherwise cnt[i] increments. On the edge where cnt[i]==DEBOUNCE_CYCLES-1,
//     btn_level[i]<=sync_btn[i] and cnt[i]<=0.
//   - Net rule: level flips on the DEBOUNCE_CYCLES-th consecutive differing edge.
//  Press: the edge on which btn_level[i] goes 0->1 sets pending[i] at that same edge.
//   If pending[i] is already 1 on that edge, the press is dropped and overflow<=1.
//  FSM IDLE:
//   - If pending!=0, grant g = first set bit scanning from rr_ptr upward, wrapping.
//   - Load evt_id<=g, evt_valid<=1, clear pending[g], go to OFFER.
//   - Latency: pending set at edge t gives evt_valid high after edge t+1.
//  FSM OFFER:
//   - Hold evt_valid=1 and evt_id stable until evt_valid&&evt_ready.
//   - On that edge: evt_valid<=0, rr_ptr<=(evt_id+1) mod N_BTN, go to IDLE.
//   - Throughput: at most one event per 2 cycles.
//  Simultaneous events:
//   - New press on channel g on the same edge pending[g] is cleared by load: pending[g] stays 1, no overflow.
//   - Overflow set and ovf_clr on the same edge: set wins.
//   - Releases generate no event.
// CONFIGURATION
//  BTN_AUTOREPEAT_EN defined:
//   - Per-channel rpt[i] counts cycles while btn_level[i]=1, cleared to 0 on the press edge and while the level is 0.
//   - On the edge where rpt[i]==REPEAT_CYCLES-1, a synthetic press is posted (same pending/overflow rules) and rpt[i]<=0.
//   - Result: repeats occur every REPEAT_CYCLES cycles after the press.
//  BTN_AUTOREPEAT_EN undefined: no repeat counters are built. A held button yields exactly one event.
// TESTING  (bench overrides DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16)
//  1 Reset with sync_btn=4'b1111 -> all outputs 0; btn_level=1111 after 4 edges following release of reset.
//  2 sync_btn[2] high 3 cycles then low -> no level change, no event.
//    Held high: btn_level[2]=1 on 4th edge, evt_valid=1/evt_id=2 next edge; evt_ready=1 -> evt_valid=0.
//  3 Buttons 0,3 debounce same edge, evt_ready=1 -> ids 0 then 3.
//    Then buttons 0,1 simultaneously with rr_ptr=0 (after id 3) -> ids 0 then 1.
//  4 evt_ready=0; btn1 pressed -> offered id 1. Second debounced press -> pending[1]=1, overflow=0.
//    Third press -> overflow=1; ovf_clr pulse -> overflow=0.
//  5 Macro defined, btn0 held, evt_ready=1 -> events id 0 at press and every 16 cycles.
//    Macro undefined -> exactly one event.
//  6 reset_n=0 while evt_valid=1 -> evt_valid=0 and pending=0 next edge.
//    btn held -> new event after 4 debounce edges plus 1.

Source files
------------

// File: rtl/btn_event_arbiter_if.sv
// Event stream between the button arbiter (master) and the game controller (slave).
// evt_id is held stable for as long as evt_valid is high.
interface btn_event_arbiter_if #(
    parameter int ID_W = 2
) ();
    logic            evt_valid;
    logic [ID_W-1:0] evt_id;
    logic            evt_ready;

    modport master (output evt_valid, output evt_id, input evt_ready);
    modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/btn_event_arbiter.sv
// Per-channel debounce, press detection and round-robin arbitration into a valid/ready event stream.
// Optional feature macro: BTN_AUTOREPEAT_EN posts a synthetic press every REPEAT_CYCLES while a button is held.
module btn_event_arbiter #(
    parameter int N_BTN           = 4,
    parameter int ID_W            = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_CYCLES   = 50000000,
    parameter int RPT_W           = 26
) (
    input  logic                Clk100MHz,
    input  logic                reset_n,
    input  logic [N_BTN-1:0]    sync_btn,
    input  logic                ovf_clr,
    btn_event_arbiter_if.master evt,
    output logic [N_BTN-1:0]    btn_level,
    output logic [N_BTN-1:0]    pending,
    output logic                overflow
);

    typedef enum logic {IDLE, OFFER} state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]  cnt [N_BTN];

    logic [N_BTN-1:0]  flip;
    logic [N_BTN-1:0]  deb_press;
    logic [N_BTN-1:0]  rpt_press;
    logic [N_BTN-1:0]  press;
    logic [N_BTN-1:0]  load_clr;
    logic [N_BTN-1:0]  drop;
    logic [ID_W-1:0]   grant;
    logic              load;

    // First requesting channel at or above ptr, wrapping around.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_BTN-1:0] req,
                                                input logic [ID_W-1:0]  ptr);
        logic [ID_W-1:0] g;
        logic            found;
        int              idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < N_BTN; k++) begin
            idx = (int'(ptr) + k) % N_BTN;
            if (!found && req[idx]) begin
                g     = ID_W'(idx);
                found = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] id);
        return (int'(id) == N_BTN - 1) ? '0 : id + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            flip[i]      = (sync_btn[i] != btn_level[i]) && (cnt[i] == DEB_LAST);
            deb_press[i] = flip[i] && sync_btn[i];
        end
        load     = (state == IDLE) && (pending != '0);
        grant    = rr_pick(pending, rr_ptr);
        load_clr = '0;
        if (load)
            load_clr[grant] = 1'b1;
        press = deb_press | rpt_press;
        // A press landing on the edge that loads the same channel re-arms it instead of overflowing.
        drop  = press & pending & ~load_clr;
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt [N_BTN];

    always_ff @(posedge Clk100MHz) begin
        for (int i = 0; i < N_BTN; i++) begin
            if (!reset_n || !btn_level[i] || rpt[i] == RPT_LAST)
                rpt[i] <= '0;
            else
                rpt[i] <= rpt[i] + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < N_BTN; i++)
            rpt_press[i] = btn_level[i] && (rpt[i] == RPT_LAST);
    end
`else
    assign rpt_press = '0;
`endif

    always_ff @(posedge Clk100MHz) begin
        if (!reset_n) begin
            btn_level <= '0;
            pending   <= '0;
            overflow  <= 1'b0;
            for (int i = 0; i < N_BTN; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (sync_btn[i] == btn_level[i]) begin
                    cnt[i] <= '0;
                end else if (flip[i]) begin
                    btn_level[i] <= sync_btn[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            pending <= (pending & ~load_clr) | press;
            if (drop != '0)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge Clk100MHz) begin
        if (!reset_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            evt.evt_valid <= 1'b0;
            evt.evt_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        evt.evt_id    <= grant;
                        evt.evt_valid <= 1'b1;
                        state         <= OFFER;
                    end
                end
                OFFER: begin
                    if (evt.evt_ready) begin
                        evt.evt_valid <= 1'b0;
                        rr_ptr        <= rr_next(evt.evt_id);
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
